core_ctrl: RTL and testbench
============================

CORE_CTRL -- requirements
Module: core_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0100_0000: PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 opcode_i  input  7  opcode of the latched instruction register (IR[6:0]).
REQ-005 mem_ack_i  input  1  memory completion for the current request.
REQ-006 alu_res_i  input  32  ALU result, used as the load/store address.
REQ-007 target_i  input  32  branch/jump target from the datapath.
REQ-008 branch_taken_i  input  1  branch comparison result.
REQ-009 pc_o  output  32  current PC.
REQ-010 mem_req_o  output  1  shared memory port request.
REQ-011 mem_we_o  output  1  write enable, valid while mem_req_o=1.
REQ-012 mem_addr_o  output  32  memory address, valid while mem_req_o=1.
REQ-013 ir_we_o  output  1  IR load strobe.
REQ-014 rf_we_o  output  1  register-file write strobe.
REQ-015 wb_sel_o  output  2  writeback source: 0=ALU, 1=MEM, 2=PC+4.
REQ-016 state_o  output  3  encoded FSM state.
REQ-017 illegal_o  output  1  sticky trap flag.
REQ-018 instret_o  output  32  retired-instruction counter.

Function
REQ-019 The FSM SHALL have these states and codes: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Codes 6 and 7 SHALL go to TRAP.
REQ-020 FETCH: drive mem_req_o=1, mem_we_o=0, mem_addr_o=pc_o; hold all three stable until mem_ack_i=1.
REQ-021 FETCH on mem_ack_i=1: pulse ir_we_o for that cycle; move to DECODE on the next cycle.
REQ-022 DECODE (1 cycle): legal opcodes go to EXEC. Legal opcodes are 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 0001111. Any other opcode, including 1110011, goes to TRAP.
REQ-023 EXEC for OP, OP-IMM, LUI, AUIPC: go to WB with wb_sel_o=0.
REQ-024 EXEC for LOAD or STORE: go to MEM.
REQ-025 EXEC for BRANCH: set pc to target_i if branch_taken_i, else pc+4; retire; go to FETCH.
REQ-026 EXEC for JAL or JALR: go to WB with wb_sel_o=2; latch target_i as next PC.
REQ-027 EXEC for FENCE: pc+4; retire; go to FETCH.
REQ-028 MEM: drive mem_req_o=1, mem_addr_o=alu_res_i, and mem_we_o=1 for STORE, 0 for LOAD; hold until mem_ack_i.
REQ-029 MEM on ack: LOAD goes to WB with wb_sel_o=1; STORE sets pc+4, retires and goes to FETCH.
REQ-030 WB (1 cycle): rf_we_o=1; update pc to pc+4, or to the latched target for JAL/JALR; retire; go to FETCH.
REQ-031 Misaligned target: if target_i[1:0]!=0 on JAL/JALR, or on a taken BRANCH, go to TRAP from EXEC. PC is not updated, there is no retire, and rf_we_o is never asserted.
REQ-032 TRAP: illegal_o=1 and all strobes 0. The block stays in TRAP until reset.
REQ-033 mem_ack_i SHALL be ignored whenever mem_req_o=0.
REQ-034 ir_we_o, rf_we_o and mem_req_o SHALL be 0 in every state not listed above for them.
REQ-035 wb_sel_o SHALL be 0 outside WB.
REQ-036 PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 = 0.
REQ-037 instret_o increments by exactly 1 per retire and wraps from 32'hFFFF_FFFF to 0.

Reset
REQ-038 While reset_n=0, with no clock required, the block SHALL hold: state=FETCH, pc_o=RESET_PC, instret_o=0, illegal_o=0, and mem_req_o, ir_we_o, rf_we_o, mem_we_o all 0.
REQ-039 Reset asserted mid-transaction SHALL drop mem_req_o in the same cycle. An ack arriving after reset is ignored.
REQ-040 After reset_n rises, mem_req_o SHALL assert on the first rising edge: FETCH at RESET_PC.

Verification
REQ-041 ADDI (0010011), ack after 3 wait cycles -> mem_addr_o=0x0100_0000 held for 4 cycles, then one ir_we_o pulse, then DECODE, EXEC, WB with rf_we_o=1 and wb_sel_o=0; pc_o=0x0100_0004 and instret_o=1.
REQ-042 LOAD with alu_res_i=0x2000 -> MEM with addr 0x2000 and we=0; WB with wb_sel_o=1. STORE -> MEM with we=1, no rf_we_o, pc+4.
REQ-043 Taken BRANCH with target_i=0x0100_0040 -> pc_o=0x0100_0040. Not taken -> pc+4. Misaligned target 0x0100_0042 -> TRAP, pc unchanged, instret_o unchanged.
REQ-044 JAL with target_i=0x0100_0100 -> WB with wb_sel_o=2 and rf_we_o=1; then pc_o=0x0100_0100.
REQ-045 Opcode 1110011 -> TRAP, illegal_o=1, and no further mem_req_o across 20 cycles and acks.
REQ-046 reset_n pulled low during a FETCH wait -> mem_req_o=0 immediately. After release, fetch from RESET_PC with instret_o=0.

Source files
------------

// File: rtl/core_ctrl.sv
// rtl/core_ctrl.sv - multi-cycle control FSM: fetch, decode, execute, memory, writeback, trap.
// Sequencing state, PC and handshake strobes are registered; ir_we_o is the only ack-qualified output.
module core_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0100_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [6:0]  opcode_i,
  input  logic        mem_ack_i,
  input  logic [31:0] alu_res_i,
  input  logic [31:0] target_i,
  input  logic        branch_taken_i,
  output logic [31:0] pc_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic        ir_we_o,
  output logic        rf_we_o,
  output logic [1:0]  wb_sel_o,
  output logic [2:0]  state_o,
  output logic        illegal_o,
  output logic [31:0] instret_o
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_e;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  state_e      state_q;
  logic [31:0] pc_q, instret_q, mem_addr_q, tgt_q;
  logic        mem_req_q, mem_we_q, rf_we_q, jump_q, illegal_q;
  logic [1:0]  wb_sel_q;

  logic        legal_op;
  logic        tgt_misaligned;
  logic [31:0] pc_inc, branch_pc_d, wb_pc_d;

  always_comb begin
    legal_op = 1'b0;
    case (opcode_i)
      OP_OP, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_FENCE: legal_op = 1'b1;
      default: legal_op = 1'b0;
    endcase
  end

  assign tgt_misaligned = |target_i[1:0];
  assign pc_inc         = pc_q + 32'd4;
  assign branch_pc_d    = branch_taken_i ? target_i : pc_inc;
  assign wb_pc_d        = jump_q ? tgt_q : pc_inc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      instret_q  <= '0;
      mem_addr_q <= '0;
      tgt_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      rf_we_q    <= 1'b0;
      jump_q     <= 1'b0;
      illegal_q  <= 1'b0;
      wb_sel_q   <= 2'd0;
    end else begin
      case (state_q)
        FETCH: begin
          // Request is raised one edge after entry only when coming out of reset.
          if (!mem_req_q) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= pc_q;
          end else if (mem_ack_i) begin
            mem_req_q <= 1'b0;
            state_q   <= DECODE;
          end
        end
        DECODE: begin
          if (legal_op) begin
            state_q <= EXEC;
          end else begin
            state_q   <= TRAP;
            illegal_q <= 1'b1;
          end
        end
        EXEC: begin
          case (opcode_i)
            OP_OP, OP_IMM, OP_LUI, OP_AUIPC: begin
              state_q  <= WB;
              rf_we_q  <= 1'b1;
              wb_sel_q <= 2'd0;
              jump_q   <= 1'b0;
            end
            OP_LOAD, OP_STORE: begin
              state_q    <= MEM;
              mem_req_q  <= 1'b1;
              mem_we_q   <= (opcode_i == OP_STORE);
              mem_addr_q <= alu_res_i;
            end
            OP_BRANCH: begin
              if (branch_taken_i && tgt_misaligned) begin
                state_q   <= TRAP;
                illegal_q <= 1'b1;
              end else begin
                pc_q       <= branch_pc_d;
                instret_q  <= instret_q + 32'd1;
                state_q    <= FETCH;
                mem_req_q  <= 1'b1;
                mem_addr_q <= branch_pc_d;
              end
            end
            OP_JAL, OP_JALR: begin
              if (tgt_misaligned) begin
                state_q   <= TRAP;
                illegal_q <= 1'b1;
              end else begin
                state_q  <= WB;
                rf_we_q  <= 1'b1;
                wb_sel_q <= 2'd2;
                tgt_q    <= target_i;
                jump_q   <= 1'b1;
              end
            end
            OP_FENCE: begin
              pc_q       <= pc_inc;
              instret_q  <= instret_q + 32'd1;
              state_q    <= FETCH;
              mem_req_q  <= 1'b1;
              mem_addr_q <= pc_inc;
            end
            default: begin
              state_q   <= TRAP;
              illegal_q <= 1'b1;
            end
          endcase
        end
        MEM: begin
          if (mem_ack_i) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (mem_we_q) begin
              pc_q       <= pc_inc;
              instret_q  <= instret_q + 32'd1;
              state_q    <= FETCH;
              mem_req_q  <= 1'b1;
              mem_addr_q <= pc_inc;
            end else begin
              state_q  <= WB;
              rf_we_q  <= 1'b1;
              wb_sel_q <= 2'd1;
              jump_q   <= 1'b0;
            end
          end
        end
        WB: begin
          rf_we_q    <= 1'b0;
          wb_sel_q   <= 2'd0;
          pc_q       <= wb_pc_d;
          instret_q  <= instret_q + 32'd1;
          state_q    <= FETCH;
          mem_req_q  <= 1'b1;
          mem_we_q   <= 1'b0;
          mem_addr_q <= wb_pc_d;
        end
        default: begin
          state_q   <= TRAP;
          illegal_q <= 1'b1;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
          rf_we_q   <= 1'b0;
          wb_sel_q  <= 2'd0;
        end
      endcase
    end
  end

  assign pc_o       = pc_q;
  assign mem_req_o  = mem_req_q;
  assign mem_we_o   = mem_we_q;
  assign mem_addr_o = mem_addr_q;
  assign ir_we_o    = (state_q == FETCH) && mem_req_q && mem_ack_i;
  assign rf_we_o    = rf_we_q;
  assign wb_sel_o   = wb_sel_q;
  assign state_o    = state_q;
  assign illegal_o  = illegal_q;
  assign instret_o  = instret_q;

endmodule

// File: tb/tb_core_ctrl.sv
// tb/tb_core_ctrl.sv - directed bench for core_ctrl with a per-instruction reference model.
module tb_core_ctrl;
  localparam logic [31:0] RPC = 32'h0100_0000;
  localparam logic [6:0] OP_OP = 7'b0110011, OP_IMM = 7'b0010011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                         OP_FENCE = 7'b0001111, OP_SYSTEM = 7'b1110011;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [6:0]  opcode_i = '0;
  logic        mem_ack_i = 1'b0;
  logic [31:0] alu_res_i = '0;
  logic [31:0] target_i = '0;
  logic        branch_taken_i = 1'b0;
  logic [31:0] pc_o, mem_addr_o, instret_o;
  logic        mem_req_o, mem_we_o, ir_we_o, rf_we_o, illegal_o;
  logic [1:0]  wb_sel_o;
  logic [2:0]  state_o;

  always #5 clk = ~clk;

  core_ctrl #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset_n(reset_n), .opcode_i(opcode_i), .mem_ack_i(mem_ack_i),
    .alu_res_i(alu_res_i), .target_i(target_i), .branch_taken_i(branch_taken_i),
    .pc_o(pc_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .ir_we_o(ir_we_o), .rf_we_o(rf_we_o), .wb_sel_o(wb_sel_o), .state_o(state_o),
    .illegal_o(illegal_o), .instret_o(instret_o)
  );

  int total = 0;
  int bad = 0;

  // Instruction kinds: 0 illegal, 1 ALU writeback, 2 load, 3 store, 4 branch, 5 jump, 6 fence.
  function automatic int classify(input logic [6:0] op);
    case (op)
      OP_OP, OP_IMM, OP_LUI, OP_AUIPC: return 1;
      OP_LOAD:   return 2;
      OP_STORE:  return 3;
      OP_BRANCH: return 4;
      OP_JAL, OP_JALR: return 5;
      OP_FENCE:  return 6;
      default:   return 0;
    endcase
  endfunction

  int          m_state, m_kind;
  logic [31:0] m_pc, m_instret, m_maddr, m_tgt;
  logic        m_started;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_state <= 0; m_kind <= 0; m_pc <= RPC; m_instret <= 0;
      m_maddr <= 0; m_tgt <= 0; m_started <= 1'b0;
    end else begin
      case (m_state)
        0: if (!m_started) m_started <= 1'b1;
           else if (mem_ack_i) m_state <= 1;
        1: begin
          m_kind  <= classify(opcode_i);
          m_state <= (classify(opcode_i) == 0) ? 5 : 2;
        end
        2: case (m_kind)
          1: m_state <= 4;
          2, 3: begin m_maddr <= alu_res_i; m_state <= 3; end
          4: if (branch_taken_i && target_i[1:0] != 2'b00) m_state <= 5;
             else begin
               m_pc <= branch_taken_i ? target_i : m_pc + 4;
               m_instret <= m_instret + 1; m_state <= 0;
             end
          5: if (target_i[1:0] != 2'b00) m_state <= 5;
             else begin m_tgt <= target_i; m_state <= 4; end
          default: begin m_pc <= m_pc + 4; m_instret <= m_instret + 1; m_state <= 0; end
        endcase
        3: if (mem_ack_i) begin
          if (m_kind == 3) begin m_pc <= m_pc + 4; m_instret <= m_instret + 1; m_state <= 0; end
          else m_state <= 4;
        end
        4: begin
          m_pc <= (m_kind == 5) ? m_tgt : m_pc + 4;
          m_instret <= m_instret + 1; m_state <= 0;
        end
        default: m_state <= 5;
      endcase
    end
  end

  int          n_ir = 0, n_rf = 0, n_req = 0, n_fetch_rpc = 0;
  logic [1:0]  last_sel = 0;
  logic [31:0] last_maddr = 0;
  logic        last_mwe = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic compare_loop();
    logic        e_req;
    logic [1:0]  e_sel;
    forever begin
      @(negedge clk);
      e_req = (m_state == 0 && m_started) || m_state == 3;
      e_sel = (m_state == 4) ? ((m_kind == 5) ? 2'd2 : (m_kind == 2) ? 2'd1 : 2'd0) : 2'd0;
      chk("state", {29'd0, state_o}, m_state);
      chk("pc", pc_o, m_pc);
      chk("instret", instret_o, m_instret);
      chk("mem_req", {31'd0, mem_req_o}, {31'd0, e_req});
      if (e_req) chk("mem_addr", mem_addr_o, (m_state == 3) ? m_maddr : m_pc);
      chk("mem_we", {31'd0, mem_we_o}, {31'd0, m_state == 3 && m_kind == 3});
      chk("ir_we", {31'd0, ir_we_o}, {31'd0, m_state == 0 && m_started && mem_ack_i});
      chk("rf_we", {31'd0, rf_we_o}, {31'd0, m_state == 4});
      chk("wb_sel", {30'd0, wb_sel_o}, {30'd0, e_sel});
      chk("illegal", {31'd0, illegal_o}, {31'd0, m_state == 5});
      if (ir_we_o) n_ir++;
      if (rf_we_o) begin n_rf++; last_sel = wb_sel_o; end
      if (mem_req_o) n_req++;
      if (mem_req_o && state_o == 3'd0 && mem_addr_o == RPC) n_fetch_rpc++;
      if (mem_req_o && state_o == 3'd3) begin last_maddr = mem_addr_o; last_mwe = mem_we_o; end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input logic [2:0] st, input string nm);
    int n = 0;
    while (!(mem_req_o && state_o == st) && n < 50) begin step(); n++; end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL %s_timeout: no request after %0d cycles", nm, n);
    end
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [31:0] alu, input logic [31:0] tgt,
                           input logic taken, input int fw, input int mw);
    int n = 0;
    opcode_i = op; alu_res_i = alu; target_i = tgt; branch_taken_i = taken;
    wait_req(3'd0, "fetch");
    repeat (fw) step();
    mem_ack_i = 1'b1; step(); mem_ack_i = 1'b0;
    if (op == OP_LOAD || op == OP_STORE) begin
      wait_req(3'd3, "mem");
      repeat (mw) step();
      mem_ack_i = 1'b1; step(); mem_ack_i = 1'b0;
    end
    while (!(state_o == 3'd0 || state_o == 3'd5) && n < 20) begin step(); n++; end
    if (n >= 20) begin
      total++; bad++;
      $display("FAIL idle_timeout: state stuck at %0d", state_o);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_pc", pc_o, RPC);
    step(); step();
    reset_n = 1'b1;
  endtask

  int b_ir, b_rf, b_req, b_frpc;

  initial begin
    fork compare_loop(); join_none
    step(); step();
    chk("reset_pc", pc_o, RPC);
    chk("reset_state", {29'd0, state_o}, 32'd0);
    chk("reset_instret", instret_o, 32'd0);
    chk("reset_illegal", {31'd0, illegal_o}, 32'd0);
    chk("reset_req", {31'd0, mem_req_o}, 32'd0);
    reset_n = 1'b1;
    step();
    chk("first_edge_req", {31'd0, mem_req_o}, 32'd1);
    chk("first_edge_addr", mem_addr_o, RPC);

    b_ir = n_ir; b_rf = n_rf; b_frpc = n_fetch_rpc;
    run_instr(OP_IMM, 0, 0, 0, 3, 0);
    chk("addi_fetch_cycles", n_fetch_rpc - b_frpc, 4);
    chk("addi_ir_pulses", n_ir - b_ir, 1);
    chk("addi_rf_pulses", n_rf - b_rf, 1);
    chk("addi_wb_sel", {30'd0, last_sel}, 32'd0);
    chk("addi_pc", pc_o, 32'h0100_0004);
    chk("addi_instret", instret_o, 32'd1);

    b_rf = n_rf;
    run_instr(OP_LOAD, 32'h2000, 0, 0, 1, 2);
    chk("load_addr", last_maddr, 32'h2000);
    chk("load_we", {31'd0, last_mwe}, 32'd0);
    chk("load_wb_sel", {30'd0, last_sel}, 32'd1);
    chk("load_rf_pulses", n_rf - b_rf, 1);
    chk("load_pc", pc_o, 32'h0100_0008);

    b_rf = n_rf;
    run_instr(OP_STORE, 32'h3000, 0, 0, 0, 1);
    chk("store_addr", last_maddr, 32'h3000);
    chk("store_we", {31'd0, last_mwe}, 32'd1);
    chk("store_rf_pulses", n_rf - b_rf, 0);
    chk("store_pc", pc_o, 32'h0100_000C);
    chk("store_instret", instret_o, 32'd3);

    run_instr(OP_BRANCH, 0, 32'h0100_0040, 1, 0, 0);
    chk("br_taken_pc", pc_o, 32'h0100_0040);
    run_instr(OP_BRANCH, 0, 32'h0100_0080, 0, 1, 0);
    chk("br_not_taken_pc", pc_o, 32'h0100_0044);
    run_instr(OP_FENCE, 0, 0, 0, 0, 0);
    chk("fence_pc", pc_o, 32'h0100_0048);
    chk("fence_instret", instret_o, 32'd6);

    b_rf = n_rf;
    run_instr(OP_JAL, 0, 32'h0100_0100, 0, 2, 0);
    chk("jal_wb_sel", {30'd0, last_sel}, 32'd2);
    chk("jal_rf_pulses", n_rf - b_rf, 1);
    chk("jal_pc", pc_o, 32'h0100_0100);

    run_instr(OP_JALR, 0, 32'hFFFF_FFFC, 0, 0, 0);
    chk("jalr_pc", pc_o, 32'hFFFF_FFFC);
    run_instr(OP_LUI, 0, 0, 0, 0, 0);
    chk("pc_wrap", pc_o, 32'h0000_0000);
    chk("wrap_instret", instret_o, 32'd9);

    run_instr(OP_BRANCH, 0, 32'h0000_0003, 0, 0, 0);
    chk("br_nt_misaligned_pc", pc_o, 32'h0000_0004);

    b_rf = n_rf;
    run_instr(OP_BRANCH, 0, 32'h0100_0042, 1, 0, 0);
    step(); step();
    chk("mis_state", {29'd0, state_o}, 32'd5);
    chk("mis_illegal", {31'd0, illegal_o}, 32'd1);
    chk("mis_pc", pc_o, 32'h0000_0004);
    chk("mis_instret", instret_o, 32'd10);
    chk("mis_rf_pulses", n_rf - b_rf, 0);

    do_reset();
    run_instr(OP_SYSTEM, 0, 0, 0, 1, 0);
    b_req = n_req;
    for (int i = 0; i < 20; i++) begin
      mem_ack_i = i[0];
      step();
    end
    mem_ack_i = 1'b0;
    chk("trap_state", {29'd0, state_o}, 32'd5);
    chk("trap_illegal", {31'd0, illegal_o}, 32'd1);
    chk("trap_reqs", n_req - b_req, 0);
    chk("trap_pc", pc_o, RPC);

    do_reset();
    opcode_i = OP_IMM;
    wait_req(3'd0, "refetch");
    step(); step();
    reset_n = 1'b0;
    mem_ack_i = 1'b1;
    #1;
    chk("midreset_req", {31'd0, mem_req_o}, 32'd0);
    chk("midreset_ir_we", {31'd0, ir_we_o}, 32'd0);
    step();
    reset_n = 1'b1;
    step();
    mem_ack_i = 1'b0;
    chk("release_req", {31'd0, mem_req_o}, 32'd1);
    chk("release_addr", mem_addr_o, RPC);
    chk("release_instret", instret_o, 32'd0);
    run_instr(OP_IMM, 0, 0, 0, 0, 0);
    chk("after_reset_pc", pc_o, RPC + 32'd4);
    chk("after_reset_instret", instret_o, 32'd1);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
